exe_ctrl: RTL

EXE_CTRL -- requirements
Module: exe_ctrl

---
 rtl/exe_ctrl_pkg.sv | 32 +++
 rtl/exe_unit.sv | 73 +++++++
 rtl/exe_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/exe_ctrl_pkg.sv
// exe_ctrl_pkg -- shared definitions for the exe_ctrl execution controller.
//   state_e      : controller FSM states (IDLE, EXEC, RESP)
//   OP_*         : ALU opcode encodings 4'b0000..4'b1011, OP_LAST marks the top
//   FLAG_*       : bit positions inside the 4-bit flag vector {PF, NF, BF1, BF0}
package exe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam logic [3:0] OP_ADD  = 4'b0000;  // A + B
  localparam logic [3:0] OP_SUB  = 4'b0001;  // A - B
  localparam logic [3:0] OP_AND  = 4'b0010;  // A & B
  localparam logic [3:0] OP_OR   = 4'b0011;  // A | B
  localparam logic [3:0] OP_XOR  = 4'b0100;  // A ^ B
  localparam logic [3:0] OP_NOTA = 4'b0101;  // ~A
  localparam logic [3:0] OP_SHL  = 4'b0110;  // A << 1
  localparam logic [3:0] OP_SHR  = 4'b0111;  // A >> 1, logical
  localparam logic [3:0] OP_SRA  = 4'b1000;  // A >>> 1, arithmetic
  localparam logic [3:0] OP_SLT  = 4'b1001;  // signed A < B ? 1 : 0
  localparam logic [3:0] OP_MIN  = 4'b1010;  // signed minimum
  localparam logic [3:0] OP_MAX  = 4'b1011;  // signed maximum
  localparam logic [3:0] OP_LAST = 4'b1011;

  localparam int FLAG_PF  = 3;
  localparam int FLAG_NF  = 2;
  localparam int FLAG_BF1 = 1;
  localparam int FLAG_BF0 = 0;

endpackage

// File: rtl/exe_unit.sv
// exe_unit -- combinational ALU datapath with flag generation.
//   arg_a_i, arg_b_i : M-bit signed operands (already registered by the caller)
//   oper_i           : N-bit opcode; codes above OP_LAST produce result 0
//   result_o         : M-bit ALU result
//   flags_o          : {PF, NF, BF1, BF0} computed on result_o
module exe_unit
  import exe_ctrl_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic [M-1:0] arg_a_i,
  input  logic [M-1:0] arg_b_i,
  input  logic [N-1:0] oper_i,
  output logic [M-1:0] result_o,
  output logic [3:0]   flags_o
);

  function automatic logic parity(input logic [M-1:0] r);
    return ^r;
  endfunction

  // BF1/BF0 look only at bits [M-1:1]: one set bit, or one clear bit (M-2 set bits).
  function automatic logic [3:0] calc_flags(input logic [M-1:0] r);
    logic [3:0] f;
    int         ones_hi;
    f       = 4'b0000;
    ones_hi = 0;
    for (int i = 1; i < M; i++) begin
      ones_hi = ones_hi + int'(r[i]);
    end
    f[FLAG_PF]  = parity(r);
    f[FLAG_NF]  = ~parity(r);
    f[FLAG_BF1] = (ones_hi == 1);
    f[FLAG_BF0] = (ones_hi == M - 2);
    return f;
  endfunction

  logic signed [M-1:0] a_s;
  logic signed [M-1:0] b_s;
  logic        [M-1:0] result_s;

  assign a_s = $signed(arg_a_i);
  assign b_s = $signed(arg_b_i);

  // Opcode decode; unused codes return zero.
  always_comb begin
    result_s = '0;
    if (oper_i > N'(OP_LAST)) begin
      result_s = '0;
    end else begin
      case (oper_i)
        N'(OP_ADD):  result_s = arg_a_i + arg_b_i;
        N'(OP_SUB):  result_s = arg_a_i - arg_b_i;
        N'(OP_AND):  result_s = arg_a_i & arg_b_i;
        N'(OP_OR):   result_s = arg_a_i | arg_b_i;
        N'(OP_XOR):  result_s = arg_a_i ^ arg_b_i;
        N'(OP_NOTA): result_s = ~arg_a_i;
        N'(OP_SHL):  result_s = {arg_a_i[M-2:0], 1'b0};
        N'(OP_SHR):  result_s = {1'b0, arg_a_i[M-1:1]};
        N'(OP_SRA):  result_s = {arg_a_i[M-1], arg_a_i[M-1:1]};
        N'(OP_SLT):  result_s = (a_s < b_s) ? {{(M-1){1'b0}}, 1'b1} : '0;
        N'(OP_MIN):  result_s = (a_s < b_s) ? arg_a_i : arg_b_i;
        N'(OP_MAX):  result_s = (a_s < b_s) ? arg_b_i : arg_a_i;
        default:     result_s = '0;
      endcase
    end
  end

  assign result_o = result_s;
  assign flags_o  = calc_flags(result_s);

endmodule

// File: rtl/exe_ctrl.sv
// exe_ctrl -- two-requester execution controller around the exe_unit ALU.
// A round-robin arbiter accepts one operation in IDLE, the operands are
// registered, the ALU runs for one cycle in EXEC and the registered result is
// held in RESP until the consumer takes it.
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_reqX_valid / o_reqX_ready    : request handshake for requester X (0/1)
//   i_reqX_argA/argB, i_reqX_oper  : operands (M bits) and opcode (N bits)
//   o_res_valid / i_res_ready      : result handshake
//   o_res_id, o_result, o_flags    : owner, result and {PF,NF,BF1,BF0}
//   o_res_err                      : illegal opcode indication
//   o_ops_done                     : wrapping count of result handshakes
// Build option: define EXE_CTRL_ILLEGAL_EN to flag opcodes above OP_LAST as
// errors and skip EXEC for them; otherwise o_res_err is constant 0.
module exe_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int M = 8,
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_req0_valid,
  input  logic         i_req1_valid,
  output logic         o_req0_ready,
  output logic         o_req1_ready,
  input  logic [M-1:0] i_req0_argA,
  input  logic [M-1:0] i_req0_argB,
  input  logic [M-1:0] i_req1_argA,
  input  logic [M-1:0] i_req1_argB,
  input  logic [N-1:0] i_req0_oper,
  input  logic [N-1:0] i_req1_oper,
  output logic         o_res_valid,
  input  logic         i_res_ready,
  output logic         o_res_id,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_flags,
  output logic         o_res_err,
  output logic [15:0]  o_ops_done
);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic [M-1:0] arg_a_q, arg_a_d;
  logic [M-1:0] arg_b_q, arg_b_d;
  logic [N-1:0] oper_q, oper_d;
  logic         id_q, id_d;
  logic         res_valid_q, res_valid_d;
  logic [M-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic [15:0]  ops_done_q, ops_done_d;
`ifdef EXE_CTRL_ILLEGAL_EN
  logic         err_q, err_d;
`endif

  logic         grant0_s, grant1_s, accept_s;
  logic [N-1:0] in_oper_s;
  logic [M-1:0] alu_result_s;
  logic [3:0]   alu_flags_s;

  exe_unit #(.M(M), .N(N)) u_exe_unit (
    .arg_a_i  (arg_a_q),
    .arg_b_i  (arg_b_q),
    .oper_i   (oper_q),
    .result_o (alu_result_s),
    .flags_o  (alu_flags_s)
  );

  // Arbitration: grants only in IDLE and out of reset; the pointer breaks ties.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if ((state_q == IDLE) && i_rst_n) begin
      if (i_req0_valid && i_req1_valid) begin
        grant0_s = ~ptr_q;
        grant1_s = ptr_q;
      end else begin
        grant0_s = i_req0_valid;
        grant1_s = i_req1_valid;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s  = grant0_s | grant1_s;
  assign in_oper_s = grant1_s ? i_req1_oper : i_req0_oper;

  // Next-state and datapath register updates for IDLE/EXEC/RESP.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    arg_a_d     = arg_a_q;
    arg_b_d     = arg_b_q;
    oper_d      = oper_q;
    id_d        = id_q;
    res_valid_d = res_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    ops_done_d  = ops_done_q;
`ifdef EXE_CTRL_ILLEGAL_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          arg_a_d = grant1_s ? i_req1_argA : i_req0_argA;
          arg_b_d = grant1_s ? i_req1_argB : i_req0_argB;
          oper_d  = in_oper_s;
          id_d    = grant1_s;
`ifdef EXE_CTRL_ILLEGAL_EN
          // Illegal opcodes bypass the ALU and answer directly with an error.
          if (in_oper_s > N'(OP_LAST)) begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            result_d    = '0;
            flags_d     = 4'b0000;
            err_d       = 1'b1;
          end else begin
            state_d     = EXEC;
          end
`else
          state_d = EXEC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        state_d     = RESP;
        res_valid_d = 1'b1;
        result_d    = alu_result_s;
        flags_d     = alu_flags_s;
`ifdef EXE_CTRL_ILLEGAL_EN
        err_d       = 1'b0;
`endif
      end
      RESP: begin
        if (i_res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          ptr_d       = ~id_q;
          ops_done_d  = ops_done_q + 16'd1;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, pointer and counter registers; reset discards any in-flight op.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q       <= 1'b0;
      arg_a_q     <= '0;
      arg_b_q     <= '0;
      oper_q      <= '0;
      id_q        <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      ops_done_q  <= 16'h0000;
`ifdef EXE_CTRL_ILLEGAL_EN
      err_q       <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      arg_a_q     <= arg_a_d;
      arg_b_q     <= arg_b_d;
      oper_q      <= oper_d;
      id_q        <= id_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      ops_done_q  <= ops_done_d;
`ifdef EXE_CTRL_ILLEGAL_EN
      err_q       <= err_d;
`endif
    end
  end

  assign o_req0_ready = grant0_s;
  assign o_req1_ready = grant1_s;
  assign o_res_valid  = res_valid_q;
  assign o_res_id     = id_q;
  assign o_result     = result_q;
  assign o_flags      = flags_q;
  assign o_ops_done   = ops_done_q;
`ifdef EXE_CTRL_ILLEGAL_EN
  assign o_res_err    = err_q;
`else
  assign o_res_err    = 1'b0;
`endif

endmodule
